// File: rtl/mem_sys_axil_pkg.sv
// Shared packages for the AXI-Lite memory requester: core widths and flag values,
// plus AXI-Lite bus widths and response codes.
package defines;
   localparam int XLEN = 32;
   typedef logic [XLEN-1:0] data_t;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic VALID   = 1'b1;
   localparam logic INVALID = 1'b0;
endpackage

package axi_defines;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;
endpackage

// File: rtl/axi_lite_interface.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi_lite_interface;
   import axi_defines::*;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/mem_sys_axil.sv
// Single-request AXI-Lite master: turns one rd/wr request into an AR/R or AW/W/B
// transaction and pulses done when it completes.
module mem_sys_axil
   import defines::*;
   import axi_defines::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   addr,
   input  data_t             data_in,
   input  logic              wr,
   input  logic              rd,
   input  logic              valid,
   input  logic [STRB_W-1:0] be,
   output data_t             data_out,
   output logic              done,
   axi_lite_interface.master axil_bus
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   addr_q;
   data_t             data_q;
   logic [STRB_W-1:0] be_q;
   logic              awvalid_q;
   logic              wvalid_q;
   logic              bready_q;
   logic              arvalid_q;
   logic              rready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         be_q      <= '0;
         data_out  <= '0;
         done      <= DISABLE;
         awvalid_q <= INVALID;
         wvalid_q  <= INVALID;
         bready_q  <= DISABLE;
         arvalid_q <= INVALID;
         rready_q  <= DISABLE;
      end else begin
         done <= DISABLE;
         case (state)
            IDLE: begin
               // A simultaneous rd+wr request is served as a write only.
               if (valid == VALID && wr) begin
                  addr_q    <= addr;
                  data_q    <= data_in;
                  be_q      <= be;
                  awvalid_q <= VALID;
                  wvalid_q  <= VALID;
                  state     <= WR_ADDR_DATA;
               end else if (valid == VALID && rd) begin
                  addr_q    <= addr;
                  arvalid_q <= VALID;
                  state     <= RD_ADDR;
               end
            end
            WR_ADDR_DATA: begin
               if (axil_bus.awready) awvalid_q <= INVALID;
               if (axil_bus.wready)  wvalid_q  <= INVALID;
               // Both channels finished, either earlier or on this edge.
               if ((!awvalid_q || axil_bus.awready) && (!wvalid_q || axil_bus.wready)) begin
                  bready_q <= ENABLE;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axil_bus.bvalid) begin
                  bready_q <= DISABLE;
                  done     <= ENABLE;
                  state    <= DONE;
               end
            end
            RD_ADDR: begin
               if (axil_bus.arready) begin
                  arvalid_q <= INVALID;
                  rready_q  <= ENABLE;
                  state     <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axil_bus.rvalid) begin
                  rready_q <= DISABLE;
                  data_out <= axil_bus.rdata;
                  done     <= ENABLE;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Payload fields read as zero whenever their channel is not being offered.
   assign axil_bus.awvalid = awvalid_q;
   assign axil_bus.awaddr  = awvalid_q ? addr_q : '0;
   assign axil_bus.awprot  = 3'b000;
   assign axil_bus.wvalid  = wvalid_q;
   assign axil_bus.wdata   = wvalid_q ? data_q : '0;
   assign axil_bus.wstrb   = wvalid_q ? be_q : '0;
   assign axil_bus.bready  = bready_q;
   assign axil_bus.arvalid = arvalid_q;
   assign axil_bus.araddr  = arvalid_q ? addr_q : '0;
   assign axil_bus.arprot  = 3'b000;
   assign axil_bus.rready  = rready_q;

endmodule

// File: tb/tb_mem_sys_axil.sv
// Bench for mem_sys_axil: delay-programmable AXI-Lite slave, vector table with
// scoreboard, plus back-to-back and mid-transaction reset sequences.
module tb_mem_sys_axil;
   import defines::*;
   import axi_defines::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   data_t       data_in = '0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic        valid = 1'b0;
   logic [3:0]  be = '0;
   data_t       data_out;
   logic        done;

   axi_lite_interface bus();

   mem_sys_axil dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
      .valid(valid), .be(be), .data_out(data_out), .done(done), .axil_bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave configuration and observation
   int          ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
   logic [31:0] next_rdata = '0;
   axi_resp_t   next_resp = OKAY;
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   bit          r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
   int          ar_hs = 0, aw_hs = 0, b_cyc = 0;
   logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;
   logic [2:0]  cap_arprot = '0, cap_awprot = '0;

   initial begin
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
         bus.arready = 0; bus.rvalid = 0;
         r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
         ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      end else begin
         if (bus.arready) bus.arready = 0;
         else if (bus.arvalid) begin
            if (ar_wait >= ar_d) begin
               bus.arready = 1; ar_hs++; cap_araddr = bus.araddr; cap_arprot = bus.arprot;
               r_pend = 1; r_wait = 0; ar_wait = 0;
            end else ar_wait++;
         end
         if (bus.rvalid) bus.rvalid = 0;
         else if (r_pend && bus.rready) begin
            if (r_wait >= r_d) begin
               bus.rvalid = 1; bus.rdata = next_rdata; bus.rresp = next_resp; r_pend = 0;
            end else r_wait++;
         end
         if (bus.awready) bus.awready = 0;
         else if (bus.awvalid) begin
            if (aw_wait >= aw_d) begin
               bus.awready = 1; aw_hs++; cap_awaddr = bus.awaddr; cap_awprot = bus.awprot;
               aw_got = 1; aw_wait = 0;
            end else aw_wait++;
         end
         if (bus.wready) bus.wready = 0;
         else if (bus.wvalid) begin
            if (w_wait >= w_d) begin
               bus.wready = 1; cap_wdata = bus.wdata; cap_wstrb = bus.wstrb;
               w_got = 1; w_wait = 0;
            end else w_wait++;
         end
         if (aw_got && w_got) begin
            b_pend = 1; aw_got = 0; w_got = 0; b_wait = 0;
         end
         if (bus.bvalid) bus.bvalid = 0;
         else if (b_pend && bus.bready) begin
            if (b_wait >= b_d) begin
               bus.bvalid = 1; bus.bresp = next_resp; b_pend = 0; b_cyc = cyc;
            end else b_wait++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      axi_resp_t   resp;
      int          ar_d, r_d, aw_d, w_d, b_d;
      logic [31:0] exp_out;
      int          exp_lat;
   } vec_t;

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_out;
      int          exp_lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];

   task automatic do_req(input vec_t v);
      exp_t e;
      int   lat, ar0, aw0;
      bit   got;
      ar_d = v.ar_d; r_d = v.r_d; aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d;
      next_rdata = v.rdata; next_resp = v.resp;
      ar0 = ar_hs; aw0 = aw_hs;
      wr = v.wr; rd = v.rd; valid = 1'b1; addr = v.addr; data_in = v.wdata; be = v.be;
      sb.push_back('{v.rd && !v.wr, v.addr, v.wdata, v.be, v.exp_out, v.exp_lat});
      lat = 0; got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            valid = 1'b0; wr = 1'b0; rd = 1'b0; addr = 32'hBAD0_0000; data_in = ~data_in;
         end
         if (done) got = 1;
      end
      if (!got) begin
         check("done_timeout", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("latency", 32'(lat), 32'(e.exp_lat));
      check("data_out", data_out, e.exp_out);
      if (e.is_rd) begin
         check("ar_count", 32'(ar_hs - ar0), 32'd1);
         check("aw_count", 32'(aw_hs - aw0), 32'd0);
         check("araddr", cap_araddr, e.addr);
         check("arprot", 32'(cap_arprot), 32'd0);
      end else begin
         check("aw_count", 32'(aw_hs - aw0), 32'd1);
         check("ar_count", 32'(ar_hs - ar0), 32'd0);
         check("awaddr", cap_awaddr, e.addr);
         check("wdata", cap_wdata, e.wdata);
         check("wstrb", 32'(cap_wstrb), 32'(e.be));
         check("awprot", 32'(cap_awprot), 32'd0);
         check("done_after_bvalid", 32'(cyc - b_cyc), 32'd1);
      end
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
   endtask

   task automatic wait_done(output int lat, output bit got);
      lat = 0; got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (done) got = 1;
      end
   endtask

   initial begin
      int  lat, ar0, dcount;
      bit  got;
      vec_t v;

      // rd/wr/addr/wdata/be/rdata/resp/ar_d/r_d/aw_d/w_d/b_d/exp_out/exp_lat
      vecs[0] = '{0, 1, 32'h10,  32'h0,        4'h0, 32'h13,        OKAY,   0, 0, 0, 0, 0, 32'h13,        3};
      vecs[1] = '{1, 0, 32'h100, 32'hDEADBEEF, 4'h3, 32'h0,         OKAY,   0, 0, 0, 2, 0, 32'h13,        5};
      vecs[2] = '{1, 1, 32'h20,  32'h12345678, 4'hF, 32'h55,        OKAY,   0, 0, 0, 0, 0, 32'h13,        3};
      vecs[3] = '{0, 1, 32'h40,  32'h0,        4'h0, 32'hA5A55A5A,  OKAY,   0, 5, 0, 0, 0, 32'hA5A55A5A,  8};
      vecs[4] = '{0, 1, 32'h44,  32'h0,        4'h0, 32'hFFFF0000,  SLVERR, 2, 0, 0, 0, 0, 32'hFFFF0000,  5};
      vecs[5] = '{1, 0, 32'h48,  32'h0BADF00D, 4'h8, 32'h0,         DECERR, 0, 0, 3, 0, 2, 32'hFFFF0000,  8};
      vecs[6] = '{1, 0, 32'h50,  32'hCAFEF00D, 4'h5, 32'h0,         OKAY,   0, 0, 1, 1, 0, 32'hFFFF0000,  4};

      repeat (3) @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_valids", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
      check("rst_araddr", bus.araddr, 32'd0);
      check("rst_awaddr", bus.awaddr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) do_req(vecs[i]);

      // Back-to-back reads with rd held high; address moves on after the first done
      ar_d = 0; r_d = 0; next_resp = OKAY; next_rdata = 32'h1111_0001;
      ar0 = ar_hs;
      addr = 32'h10; rd = 1'b1; valid = 1'b1; wr = 1'b0;
      wait_done(lat, got);
      check("b2b_first_done", 32'(got), 32'd1);
      check("b2b_first_data", data_out, 32'h1111_0001);
      check("b2b_first_araddr", cap_araddr, 32'h10);
      addr = 32'h14; next_rdata = 32'h2222_0002;
      wait_done(lat, got);
      check("b2b_second_done", 32'(got), 32'd1);
      check("b2b_gap", 32'(lat), 32'd4);
      check("b2b_second_araddr", cap_araddr, 32'h14);
      check("b2b_second_data", data_out, 32'h2222_0002);
      rd = 1'b0; valid = 1'b0;
      dcount = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("b2b_no_extra_done", 32'(dcount), 32'd0);
      check("b2b_ar_count", 32'(ar_hs - ar0), 32'd2);

      // Reset while waiting in RD_DATA
      r_d = 20; next_rdata = 32'h9999_9999;
      addr = 32'h30; rd = 1'b1; valid = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         rd = 1'b0; valid = 1'b0;
         if (bus.rready) got = 1;
      end
      check("rst_reach_rd_data", 32'(got), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_rready", 32'(bus.rready), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_data_out", data_out, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("midrst_no_done", 32'(dcount), 32'd0);
      check("midrst_data_hold", data_out, 32'd0);

      v = '{0, 1, 32'h34, 32'h0, 4'h0, 32'h77, OKAY, 0, 0, 0, 0, 0, 32'h77, 3};
      do_req(v);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
